// File: rtl/fold_out_collector.sv
// fold_out_collector: tracks the 2-way fold phase, discards warm-up samples and
// queues phase-0 filter outputs in a first-word fall-through FIFO for the sink.
module fold_out_collector #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_W-1:0]   fold_in,
    input  logic                       en,
    output logic signed [DATA_W-1:0]   m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       warm_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(WARMUP + 2);

    logic              phase;
    logic [WW-1:0]     warm_cnt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              capture;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr;

    assign capture = ~phase & en;
    assign push    = capture & warm_done;
    assign pop     = m_valid & m_ready;
    assign full    = fifo_level == LW'(DEPTH);
    // a full FIFO still accepts when the head leaves in the same cycle
    assign wr      = push & (~full | pop);
    assign m_valid = fifo_level != '0;
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            warm_cnt   <= '0;
            warm_done  <= 1'(WARMUP == 0);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            phase <= ~phase;
            if (capture && !warm_done) begin
                warm_cnt  <= warm_cnt + 1'b1;
                warm_done <= warm_cnt == WW'(WARMUP - 1);
            end
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(wr) - LW'(pop);
            if (push && full && !pop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= fold_in;
    end
endmodule
